// File: rtl/tbird_seq_lights_pkg.sv
// Shared types and helpers for the Thunderbird tail-light sequencer.
package tbird_pkg;

  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ, DARK} tbird_state_t;

  // Widest lamp bank per side the sequencer supports.
  localparam int MAX_LAMPS = 8;

  // k low-order ones, clipped to the lamp count of one side.
  function automatic logic [MAX_LAMPS-1:0] lamp_mask(input logic [3:0] k, input int lamps);
    logic [MAX_LAMPS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if ((i < int'(k)) && (i < lamps)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tbird_seq_lights_if.sv
// Request/lamp bundle between the turn-signal controls and the sequencer.
interface tbird_seq_lights_if #(
  parameter int LAMPS = 3
);
  logic                 left;
  logic                 right;
  logic                 hazard;
  logic [2*LAMPS-1:0]   lights;
  logic                 busy;

  modport master (output left, output right, output hazard, input lights, input busy);
  modport slave  (input left, input right, input hazard, output lights, output busy);
endinterface

// File: rtl/tbird_seq_lights_step_div.sv
// Step prescaler: emits a single-cycle strobe every DIV cycles while run is high.
module step_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic step
);
  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign step = run && (cnt == CW'(DIV - 1));

  // Count while running; dropping run clears the count so a new phase starts at 0.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/tbird_seq_lights.sv
// Thunderbird tail-light sequencer: turn sweeps, hazard sweeps and a dark gap.
module tbird_seq_lights
  import tbird_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  tbird_seq_lights_if.slave  bus
);
  tbird_state_t state;
  logic [3:0]   k;
  logic         preempt;
  logic         run;
  logic         step;

  // A turn sweep yields to hazard (or both turn stalks) immediately.
  assign preempt = ((state == LEFT) || (state == RIGHT)) &&
                   (bus.hazard || (bus.left && bus.right));
  // Holding the prescaler low on preemption restarts the HAZ phase from 0.
  assign run     = (state != IDLE) && !preempt;

  step_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .step  (step)
  );

  // Sequencer FSM: IDLE decode, sweep stepping, preemption and dark gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= 4'd1;
    end else begin
      case (state)
        IDLE: begin
          k <= 4'd1;
          if (bus.hazard || (bus.left && bus.right)) state <= HAZ;
          else if (bus.left)                         state <= LEFT;
          else if (bus.right)                        state <= RIGHT;
          else                                       state <= IDLE;
        end
        LEFT, RIGHT, HAZ: begin
          if (preempt) begin
            state <= HAZ;
            k     <= 4'd1;
          end else if (step) begin
            if (k == 4'(LAMPS)) state <= DARK;
            else                k     <= k + 4'd1;
          end
        end
        DARK: begin
          if (step) begin
            state <= IDLE;
            k     <= 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          k     <= 4'd1;
        end
      endcase
    end
  end

  logic [LAMPS-1:0] lmask;
  logic [LAMPS-1:0] rmask;

  // Lamp decode from registered state only; right half is mirrored so lamp A sits next to the centre.
  always_comb begin
    lmask      = LAMPS'(lamp_mask(k, LAMPS));
    rmask      = '0;
    for (int i = 0; i < LAMPS; i++) rmask[i] = lmask[LAMPS-1-i];
    bus.lights = '0;
    case (state)
      LEFT:    bus.lights[2*LAMPS-1:LAMPS] = lmask;
      RIGHT:   bus.lights[LAMPS-1:0]       = rmask;
      HAZ:     bus.lights                  = {lmask, rmask};
      default: bus.lights                  = '0;
    endcase
    bus.busy = (state != IDLE);
  end
endmodule

// File: tb/tb_tbird_seq_lights.sv
// Scoreboard bench for tbird_seq_lights: LAMPS=3/DIV=4 and LAMPS=4/DIV=1 side by side.
module tb_tbird_seq_lights;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  tbird_seq_lights_if #(.LAMPS(3)) bus_a ();
  tbird_seq_lights_if #(.LAMPS(4)) bus_b ();

  tbird_seq_lights #(.LAMPS(3), .DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  tbird_seq_lights #(.LAMPS(4), .DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; t = cycles since sweep start.
  int lp[2] = '{3, 4};
  int dp[2] = '{4, 1};
  int mmode[2];
  int mt[2];

  typedef struct {
    logic [15:0] lights;
    logic        busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [15:0] pattern(input int id);
    logic [15:0] p;
    int L, D, kk;
    p  = '0;
    L  = lp[id];
    D  = dp[id];
    if (mmode[id] == 0 || mt[id] >= L * D) return p;
    kk = mt[id] / D + 1;
    for (int j = 0; j < kk; j++) begin
      if (mmode[id] == 1 || mmode[id] == 3) p[L + j]     = 1'b1;
      if (mmode[id] == 2 || mmode[id] == 3) p[L - 1 - j] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_edge(input int id, input logic l, input logic r, input logic h, input logic rs);
    int L, D;
    L = lp[id];
    D = dp[id];
    if (rs) begin
      mmode[id] = 0;
      mt[id]    = 0;
    end else if (mmode[id] == 0) begin
      mt[id]    = 0;
      mmode[id] = (h || (l && r)) ? 3 : (l ? 1 : (r ? 2 : 0));
    end else if ((mmode[id] == 1 || mmode[id] == 2) && mt[id] < L * D && (h || (l && r))) begin
      mmode[id] = 3;
      mt[id]    = 0;
    end else begin
      mt[id]++;
      if (mt[id] == (L + 1) * D) mmode[id] = 0;
    end
  endtask

  task automatic cyc(input logic l, input logic r, input logic h, input logic rs, input string tag,
                     output logic [15:0] oa, output logic [15:0] ob);
    exp_t ea, eb;
    @(negedge clk);
    reset        = rs;
    bus_a.left   = l;  bus_a.right = r;  bus_a.hazard = h;
    bus_b.left   = l;  bus_b.right = r;  bus_b.hazard = h;
    @(posedge clk);
    model_edge(0, l, r, h, rs);
    model_edge(1, l, r, h, rs);
    qa.push_back('{pattern(0), mmode[0] != 0});
    qb.push_back('{pattern(1), mmode[1] != 0});
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    oa = 16'(bus_a.lights);
    ob = 16'(bus_b.lights);
    chk($sformatf("%s/%0d a.lights", tag, ncyc), oa, ea.lights);
    chk($sformatf("%s/%0d a.busy", tag, ncyc), 16'(bus_a.busy), 16'(ea.busy));
    chk($sformatf("%s/%0d b.lights", tag, ncyc), ob, eb.lights);
    chk($sformatf("%s/%0d b.busy", tag, ncyc), 16'(bus_b.busy), 16'(eb.busy));
    ncyc++;
  endtask

  task automatic idle(input int n);
    logic [15:0] oa, ob;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle", oa, ob);
  endtask

  initial begin
    logic [15:0] oa, ob;
    logic [15:0] ta;
    logic [15:0] tb6[6];
    tb6 = '{16'h10, 16'h30, 16'h70, 16'hF0, 16'h00, 16'h00};
    mmode = '{0, 0};
    mt    = '{0, 0};
    reset = 1'b1;
    bus_a.left = 1'b0; bus_a.right = 1'b0; bus_a.hazard = 1'b0;
    bus_b.left = 1'b0; bus_b.right = 1'b0; bus_b.hazard = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst", oa, ob);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst", oa, ob);
    chk("rst_a_lights", oa, 16'h0);
    chk("rst_b_lights", ob, 16'h0);
    idle(2);

    // Left held: full sweeps, dark gap, restart
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "left", oa, ob);
      if (i < 4)       ta = 16'b001000;
      else if (i < 8)  ta = 16'b011000;
      else if (i < 12) ta = 16'b111000;
      else if (i < 17) ta = 16'b000000;
      else             ta = 16'b001000;
      chk($sformatf("left_tbl_a/%0d", i), oa, ta);
      chk($sformatf("left_tbl_b/%0d", i), ob, tb6[i % 6]);
    end
    idle(20);

    // Right single-cycle pulse: one sweep only
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "rpulse", oa, ob);
    chk("rpulse_a_first", oa, 16'b000100);
    idle(22);

    // Both stalks pulse, then hazard alone
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "lr", oa, ob);
    chk("lr_a_first", oa, 16'b001100);
    idle(20);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "haz", oa, ob);
    chk("haz_a_first", oa, 16'b001100);
    idle(20);

    // Hazard preempts a running left sweep
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 1'b0, (i == 6), 1'b0, "preempt", oa, ob);
      if (i == 6)  chk("preempt_a_c6", oa, 16'b001100);
      if (i == 10) chk("preempt_a_c10", oa, 16'b011110);
    end
    idle(20);

    // Reset mid-sweep with left still held
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, (i == 5), "midrst", oa, ob);
      if (i == 5) begin
        chk("midrst_a_dark", oa, 16'h0);
        chk("midrst_a_busy", 16'(bus_a.busy), 16'h0);
      end
      if (i == 6) chk("midrst_a_restart", oa, 16'b001000);
    end
    idle(20);

    // Random requests with occasional reset
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 40) == 0), "rand", oa, ob);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbird_seq_lights.md
Name: tbird_seq_lights

Overview:
- Parametrised Thunderbird tail-light sequencer, second generation of the lab's turn-signal FSM.
- Generalises the lamp count per side and adds an internal step prescaler.
- Signal repeats while the request is held, with a dark gap between sweeps; hazard preempts a running turn sweep.
- Drives the board LED bank directly from the top level.

Parameters:
- LAMPS, 3, lamps per side; legal range 1..8.
- DIV, 4, clk cycles per sequence step; legal range 1..65535 (1 = advance every cycle).
- CW, $clog2(DIV+1), prescaler counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- left  input  1  left-turn request, level-sensitive.
- right  input  1  right-turn request, level-sensitive.
- hazard  input  1  explicit hazard request, level-sensitive.
- lights  output  2*LAMPS  lamp drive.
  - Left lamps are the upper half: lamp A (innermost) at bit LAMPS, outermost at bit 2*LAMPS-1.
  - Right lamps are the lower half: lamp A at bit LAMPS-1, outermost at bit 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. No asynchronous paths.
- Reset:
  - At a posedge with reset=1: state=IDLE, k=1, cnt=0, lights=0, busy=0.
  - Reset overrides every other event, including mid-sequence reset.
- States: IDLE, LEFT, RIGHT, HAZ, DARK. Step index k ranges 1..LAMPS. Prescaler cnt ranges 0..DIV-1.
- step: asserted when cnt==DIV-1 and state != IDLE.
  - cnt is held at 0 in IDLE.
  - Otherwise cnt increments and wraps to 0 on step.
- Outputs are decoded combinationally from registered state/k only; no input reaches an output combinationally.
  - IDLE, DARK: lights=0.
  - LEFT: the k innermost left lamps are lit; the right half is 0.
  - RIGHT: the k innermost right lamps are lit; the left half is 0.
  - HAZ: the k innermost lamps on both sides are lit.
- IDLE decode, sampled at each posedge. Priority: hazard or (left and right) -> HAZ; else left -> LEFT; else right -> RIGHT; else stay IDLE.
  - Entry always sets k=1 and cnt=0.
  - Latency: a request high at edge n gives a one-lamp pattern from edge n onward.
- Running states (LEFT/RIGHT/HAZ):
  - On step with k<LAMPS: k <= k+1.
  - On step with k==LAMPS: go to DARK, cnt=0.
  - Each pattern is held exactly DIV cycles.
- DARK: lasts DIV cycles; on step go to IDLE with k=1.
  - IDLE always lasts at least 1 cycle.
  - Held-request period = (LAMPS+1)*DIV + 1 cycles.
- Request deassertion mid-sweep: the sweep and DARK complete, then the block idles. A 1-cycle request pulse therefore yields one full sweep.
- Preemption:
  - In LEFT or RIGHT, if hazard or (left and right) is sampled high, the next state is HAZ with k=1, cnt=0, effective at that same edge (no step wait).
  - HAZ is never preempted.
  - LEFT<->RIGHT switches are ignored until the block returns to IDLE.
  - DARK ignores all inputs.
- LAMPS=1 edge case: each sweep is one lit step followed by DARK. k never increments; the k==LAMPS rule applies at the first step.
- No counter may overflow: k saturates at LAMPS by construction, and cnt wraps at DIV-1.

Decomposition:
- Package tbird_pkg:
  - typedef enum logic [2:0] tbird_state_t {IDLE, LEFT, RIGHT, HAZ, DARK};
  - function lamp_mask(k, LAMPS), returning k low-order ones.
- Sub-module step_div (prescaler):
  - Ports: clk, reset, run, step; parameter DIV.
  - Isolates cnt so the FSM sees only a single-cycle step strobe.
- The FSM and lamp decode live in tbird_seq_lights.

Test Plan (LAMPS=3, DIV=4 unless stated):
- Left held from edge 0 -> lights=001000 for cycles 0-3, 011000 for 4-7, 111000 for 8-11, 000000 for 12-16; 001000 again at cycle 17. busy=1 for cycles 0-15.
- Right high for 1 cycle -> one sweep: 000100, 000110, 000111, each for 4 cycles, then 000000. busy drops after the DARK phase; no second sweep.
- Left and right together, and separately hazard alone -> 001100, 011110, 111111, each for 4 cycles; identical timing in both cases.
- Left held; hazard asserted at cycle 6 -> lights=001100 at cycle 6, 011110 at cycle 10. Releasing hazard at cycle 7 still completes the HAZ sweep.
- Reset pulsed at cycle 5 of a left sweep -> lights=0 and busy=0 after that edge. With left still held, 001000 appears at the next edge.
- LAMPS=4, DIV=1, left held -> 00010000, 00110000, 01110000, 11110000, 00000000 (DARK), 00000000 (IDLE), then 00010000: period 6 cycles.
